// File: rtl/commonlib_muxn_stream_if.sv
// Bundle of the N:1 stream mux producer-side and consumer-side signals.
// The master modport is the environment and the slave modport is the mux.
interface commonlib_muxn_stream_if #(
  parameter int N = 2,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  in_sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  modport master (
    output in_data, in_valid, in_last, in_sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src
  );

  modport slave (
    input  in_data, in_valid, in_last, in_sel, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src
  );
endinterface

// File: rtl/commonlib_muxn_stream.sv
// N:1 valid/ready stream mux with one registered output beat, select-driven or
// round-robin grant, and optional packet lock that holds the grant until a last beat.
module commonlib_muxn_stream #(
  parameter int N    = 2,
  parameter int W    = 1,
  parameter int MODE = 0,
  parameter int LOCK = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  commonlib_muxn_stream_if.slave        bus
);
  localparam int SW = $clog2(N);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    r_state;
  logic [SW-1:0] r_lock_ch;
  logic [SW-1:0] r_ptr;
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic          r_last;
  logic [SW-1:0] r_src;

  logic          w_can_take;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt;
  logic [SW-1:0] w_scan;
  logic          w_xfer;
  logic [W-1:0]  w_data;
  logic          w_last;

  assign w_can_take = !r_valid || bus.out_ready;

  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_scan    = '0;
    if (LOCK != 0 && r_state == ST_LOCKED) begin
      w_gnt     = r_lock_ch;
      w_gnt_vld = 1'b1;
    end else if (MODE == 0) begin
      if (32'(bus.in_sel) < N) begin
        w_gnt     = bus.in_sel;
        w_gnt_vld = 1'b1;
      end
    end else begin
      // Scan from farthest to nearest so the channel right after r_ptr wins.
      for (int k = N; k >= 1; k--) begin
        w_scan = SW'((32'(r_ptr) + 32'(k)) % N);
        if (bus.in_valid[w_scan]) begin
          w_gnt     = w_scan;
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SW'(i)) begin
        w_data = bus.in_data[i*W +: W];
        w_last = bus.in_last[i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign bus.in_ready[i] = w_can_take && w_gnt_vld && (w_gnt == SW'(i));
  end

  assign w_xfer = w_can_take && w_gnt_vld && bus.in_valid[w_gnt];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_src     <= '0;
      r_ptr     <= SW'(N - 1);
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_last  <= w_last;
        r_src   <= w_gnt;
        r_ptr   <= w_gnt;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
      if (LOCK != 0 && w_xfer) begin
        if (r_state == ST_IDLE && !w_last) begin
          r_state   <= ST_LOCKED;
          r_lock_ch <= w_gnt;
        end else if (r_state == ST_LOCKED && w_last) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign bus.out_src   = r_src;
endmodule

// File: tb/tb_commonlib_muxn_stream.sv
// Randomized scoreboard bench for commonlib_muxn_stream across three builds:
// select-driven N=6, round-robin N=4, and round-robin with packet lock N=5.
module tb_commonlib_muxn_stream;
  localparam int NCFG = 3;
  localparam int NCYC = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  typedef struct {
    int       src;
    bit [7:0] data;
    bit       last;
  } item_t;

  task automatic chk(input int cfg, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0h, expected %0h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int CN  = (c == 0) ? 6 : ((c == 1) ? 4 : 5);
    localparam int CM  = (c == 0) ? 0 : 1;
    localparam int CL  = (c == 2) ? 1 : 0;
    localparam int CSW = $clog2(CN);

    logic rst_n;
    commonlib_muxn_stream_if #(.N(CN), .W(8)) bus ();

    commonlib_muxn_stream #(.N(CN), .W(8), .MODE(CM), .LOCK(CL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Driver: a saturated phase, a heavy-backpressure phase, random resets elsewhere.
    initial begin
      rst_n         = 1'b0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.in_last   = '0;
      bus.in_sel    = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
        @(posedge clk);
        #1;
        rst_n = !(cyc > 40 && $urandom_range(80) == 0);
        for (int i = 0; i < CN; i++) begin
          bus.in_valid[i]        = (cyc < 30) ? 1'b1 : ($urandom_range(3) != 0);
          bus.in_data[i*8 +: 8]  = 8'($urandom_range(255));
          bus.in_last[i]         = ($urandom_range(2) == 0);
        end
        bus.in_sel = CSW'($urandom_range((1 << CSW) - 1));
        if (cyc < 30)
          bus.out_ready = 1'b1;
        else if (cyc >= 200 && cyc < 280)
          bus.out_ready = ($urandom_range(3) == 0);
        else
          bus.out_ready = ($urandom_range(3) != 0);
      end
      @(posedge clk);
      n_done++;
    end

    // Reference model + monitor, evaluated mid-cycle while inputs are stable.
    item_t    q[$];
    int       m_ptr;
    bit       m_lock;
    int       m_ch;
    bit       m_rst_seen;

    always @(negedge clk) begin
      int         g;
      bit         gv;
      bit         can;
      bit [CN-1:0] exp_rdy;
      bit [CN-1:0] vld;
      item_t      it;
      if (!rst_n) begin
        q.delete();
        m_ptr      = CN - 1;
        m_lock     = 1'b0;
        m_ch       = 0;
        m_rst_seen = 1'b1;
      end else begin
        chk(c, "out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (m_rst_seen) begin
          chk(c, "reset out_data", 64'(bus.out_data), 64'd0);
          chk(c, "reset out_src", 64'(bus.out_src), 64'd0);
          chk(c, "reset out_last", 64'(bus.out_last), 64'd0);
        end
        m_rst_seen = 1'b0;
        if (q.size() != 0) begin
          chk(c, "out_data", 64'(bus.out_data), 64'(q[0].data));
          chk(c, "out_src", 64'(bus.out_src), 64'(q[0].src));
          chk(c, "out_last", 64'(bus.out_last), 64'(q[0].last));
        end
        vld = bus.in_valid;
        can = (q.size() == 0) || bus.out_ready;
        g   = 0;
        gv  = 1'b0;
        if (CL != 0 && m_lock) begin
          g  = m_ch;
          gv = 1'b1;
        end else if (CM == 0) begin
          g  = int'(bus.in_sel);
          gv = (g < CN);
        end else begin
          for (int k = 1; k <= CN && !gv; k++) begin
            if (vld[(m_ptr + k) % CN]) begin
              g  = (m_ptr + k) % CN;
              gv = 1'b1;
            end
          end
        end
        exp_rdy = '0;
        if (gv && can) exp_rdy[g] = 1'b1;
        chk(c, "in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (gv && can && vld[g]) begin
          it.src  = g;
          it.data = bus.in_data[g*8 +: 8];
          it.last = bus.in_last[g];
          q.push_back(it);
          m_ptr = g;
          if (CL != 0) begin
            if (!m_lock && !it.last) begin
              m_lock = 1'b1;
              m_ch   = g;
            end else if (m_lock && it.last) begin
              m_lock = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    fork
      begin
        wait (n_done == NCFG);
      end
      begin
        repeat (NCYC * 4 + 100) @(posedge clk);
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got %0d configs finished, expected %0d", n_done, NCFG);
      end
    join_any
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
